// File: rtl/poly_compressor_if.sv
// Coefficient-RAM read port, byte-RAM write port and start/done handshake
// of the 3-bit polynomial compressor.
interface poly_compressor_if;
   logic        start;
   logic        done;
   logic [8:0]  poly_addr;
   logic [15:0] poly_do;
   logic        byte_we;
   logic [9:0]  byte_addr;
   logic [7:0]  byte_di;

   modport master (
      input  start, poly_do,
      output done, poly_addr, byte_we, byte_addr, byte_di
   );

   modport slave (
      output start, poly_do,
      input  done, poly_addr, byte_we, byte_addr, byte_di
   );
endinterface

// File: rtl/poly_compressor.sv
// Compresses 512 coefficients mod 12289 to 3 bits each and packs every
// group of 8 results into 3 bytes of byte RAM starting at BYTE_BASE.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing coefficient reads 0..511
// DRAIN | finishing pack/write pipeline after the last read
// FIN   | one-cycle done pulse
module poly_compressor #(
   parameter logic [9:0] BYTE_BASE = 10'd0
) (
   input  logic            clk,
   input  logic            rst,
   poly_compressor_if.master bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t      state, state_nx;
   logic [9:0]  cyc;
   logic [8:0]  poly_addr_q;
   logic [23:0] pack, hold;
   logic        byte_we_q;
   logic [9:0]  byte_addr_q;
   logic [7:0]  byte_di_q;
   logic [13:0] x, xr;
   logic [2:0]  t_new;
   logic        active, reading, done_c, wr_slot;
   logic        unused_hi;

   assign unused_hi = ^bus.poly_do[15:14];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = RUN;
         RUN:     if (cyc == 10'd511) state_nx = DRAIN;
         DRAIN:   if (cyc == 10'd517) state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      active  = (state == RUN) || (state == DRAIN);
      reading = (state == RUN);
      done_c  = (state == FIN);
   end

   // Rounding thresholds: t >= i exactly when 8x'+6144 >= 12289*i.
   always_comb begin
      x  = bus.poly_do[13:0];
      xr = (x >= 14'd12289) ? x - 14'd12289 : x;
      if      (xr >= 14'd11521) t_new = 3'd0;
      else if (xr >= 14'd9985)  t_new = 3'd7;
      else if (xr >= 14'd8449)  t_new = 3'd6;
      else if (xr >= 14'd6913)  t_new = 3'd5;
      else if (xr >= 14'd5377)  t_new = 3'd4;
      else if (xr >= 14'd3841)  t_new = 3'd3;
      else if (xr >= 14'd2305)  t_new = 3'd2;
      else if (xr >= 14'd769)   t_new = 3'd1;
      else                      t_new = 3'd0;
   end

   // Write slots are the three cycles following each completed group.
   assign wr_slot = active && (cyc >= 10'd10) && (cyc <= 10'd516) &&
                    ((cyc[2:0] == 3'd2) || (cyc[2:0] == 3'd3) || (cyc[2:0] == 3'd4));

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc         <= '0;
         poly_addr_q <= '0;
         pack        <= '0;
         hold        <= '0;
         byte_we_q   <= 1'b0;
         byte_addr_q <= '0;
         byte_di_q   <= '0;
      end else begin
         if (state == IDLE) cyc <= '0;
         else               cyc <= cyc + 10'd1;
         if (reading) poly_addr_q <= cyc[8:0];
         if (active && (cyc >= 10'd2) && (cyc <= 10'd513))
            pack <= {t_new, pack[23:3]};
         if (active && (cyc >= 10'd10) && (cyc[2:0] == 3'd2))
            hold <= pack;
         byte_we_q <= wr_slot;
         if (wr_slot) begin
            case (cyc[2:0])
               3'd2: begin
                  byte_di_q   <= pack[7:0];
                  byte_addr_q <= (cyc == 10'd10) ? BYTE_BASE : byte_addr_q + 10'd1;
               end
               3'd3: begin
                  byte_di_q   <= hold[15:8];
                  byte_addr_q <= byte_addr_q + 10'd1;
               end
               default: begin
                  byte_di_q   <= hold[23:16];
                  byte_addr_q <= byte_addr_q + 10'd1;
               end
            endcase
         end
      end
   end

   assign bus.done      = done_c;
   assign bus.poly_addr = poly_addr_q;
   assign bus.byte_we   = byte_we_q;
   assign bus.byte_addr = byte_addr_q;
   assign bus.byte_di   = byte_di_q;

endmodule
